// File: rtl/fmap_buf_pkg.sv
// Shared types and default sizes for the feature-map buffer sequencer.
// Contents:
//   state_t       - controller states (IDLE, WRITE, READ, DRAIN)
//   L_DEPTH/L_AW  - "L" buffer: 16*10*10 words, 11-bit address
//   R_DEPTH/R_AW  - "R" buffer: 64*28*28 words, 16-bit address
//   DEFAULT_DW    - word width
package fmap_buf_pkg;

    localparam int L_DEPTH    = 1600;
    localparam int L_AW       = 11;
    localparam int R_DEPTH    = 64 * 28 * 28;
    localparam int R_AW       = 16;
    localparam int DEFAULT_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/fmap_buf_ctrl_skid.sv
// Two-entry FIFO that catches RAM read data the consumer is not ready for.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset (empties FIFO)
//   push, din       - write one entry
//   pop             - drop the head entry
//   dout            - head entry (valid when count != 0)
//   count           - number of stored entries, 0..2
module fmap_skid2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;

    // entry0 is always the head; a pop shifts entry1 forward so the
    // output never needs a read-pointer mux.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= din;
                    end else begin
                        entry1 <= din;
                    end
                    if (count != 2'd2) begin
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    if (count != 2'd0) begin
                        entry0 <= entry1;
                        count  <= count - 2'd1;
                    end
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= din;
                    end else if (count == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end else begin
                        entry0 <= din;
                        count  <= 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout = entry0;

endmodule

// File: rtl/fmap_buf_ctrl.sv
// Fill/drain sequencer for one dual-port feature-map block RAM.
// Every beat moves two words: port A at the even address, port B at odd.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   wr_start                   - pulse in IDLE to start a fill
//   wr_valid/wr_ready/wr_data  - producer handshake, {word 2k, word 2k+1}
//   rd_start                   - pulse in IDLE to start a drain
//   rd_valid/rd_ready/rd_data  - consumer handshake, {mem[2k], mem[2k+1]}
//   busy                       - controller not IDLE
//   wr_done, rd_done           - one-cycle completion pulses
//   ram_*                      - RAM control, write data and read data
module fmap_buf_ctrl
    import fmap_buf_pkg::*;
#(
    parameter int DEPTH = L_DEPTH,
    parameter int AW    = L_AW,
    parameter int DW    = DEFAULT_DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_start,
    input  logic            wr_valid,
    input  logic [2*DW-1:0] wr_data,
    output logic            wr_ready,
    input  logic            rd_start,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [2*DW-1:0] rd_data,
    output logic            busy,
    output logic            wr_done,
    output logic            rd_done,
    output logic            ram_en,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addra,
    output logic [AW-1:0]   ram_addrb,
    output logic [DW-1:0]   ram_dina,
    output logic [DW-1:0]   ram_dinb,
    input  logic [DW-1:0]   ram_douta,
    input  logic [DW-1:0]   ram_doutb
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 2);

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   next_ptr;
    logic            inflight;
    logic            next_inflight;
    logic            next_wr_done;

    logic [1:0]      skid_count;
    logic [2*DW-1:0] skid_head;
    logic            skid_empty;
    logic            skid_push;
    logic            skid_pop;
    logic            rd_pop;
    logic [2*DW-1:0] ram_word_pair;

    assign ram_word_pair = {ram_douta, ram_doutb};
    assign skid_empty    = (skid_count == 2'd0);

    // RAM data arriving while the skid buffer is empty is presented to the
    // consumer directly, which is what gives rd_valid two cycles after
    // rd_start.  It is only captured when the consumer does not take it.
    assign rd_valid  = !skid_empty || inflight;
    assign rd_pop    = rd_valid && rd_ready;
    assign skid_pop  = rd_pop && !skid_empty;
    assign skid_push = inflight && !(rd_pop && skid_empty);
    assign rd_data   = !skid_empty ? skid_head :
                       (inflight ? ram_word_pair : '0);
    assign busy      = (state != IDLE);

    fmap_skid2 #(
        .W (2*DW)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (skid_push),
        .pop   (skid_pop),
        .din   (ram_word_pair),
        .dout  (skid_head),
        .count (skid_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            inflight <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            state    <= next_state;
            ptr      <= next_ptr;
            inflight <= next_inflight;
            wr_done  <= next_wr_done;
        end
    end

    // Reads issue only while buffered plus in-flight data stays below two,
    // or when a beat leaves this cycle; that bound keeps the two-entry skid
    // buffer from overflowing whatever the consumer does.
    always_comb begin
        next_state    = state;
        next_ptr      = ptr;
        next_inflight = 1'b0;
        next_wr_done  = 1'b0;
        wr_ready      = 1'b0;
        rd_done       = 1'b0;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_addra     = '0;
        ram_addrb     = '0;
        ram_dina      = '0;
        ram_dinb      = '0;

        case (state)
            IDLE: begin
                next_ptr = '0;
                if (wr_start) begin
                    next_state = WRITE;
                end else if (rd_start) begin
                    next_state = READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addra = ptr;
                    ram_addrb = ptr + AW'(1);
                    ram_dina  = wr_data[2*DW-1:DW];
                    ram_dinb  = wr_data[DW-1:0];
                    if (ptr == LAST_PTR) begin
                        next_state   = IDLE;
                        next_ptr     = '0;
                        next_wr_done = 1'b1;
                    end else begin
                        next_ptr = ptr + AW'(2);
                    end
                end
            end
            READ: begin
                if ((({1'b0, skid_count} + {2'b00, inflight}) < 3'd2) || rd_pop) begin
                    ram_en        = 1'b1;
                    ram_addra     = ptr;
                    ram_addrb     = ptr + AW'(1);
                    next_inflight = 1'b1;
                    if (ptr == LAST_PTR) begin
                        next_state = DRAIN;
                        next_ptr   = '0;
                    end else begin
                        next_ptr = ptr + AW'(2);
                    end
                end
            end
            DRAIN: begin
                if (skid_empty && !inflight) begin
                    rd_done    = 1'b1;
                    next_state = IDLE;
                    next_ptr   = '0;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
